// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address decode for the data-memory responder
//   Provides: DATA_W, CNT_W, state_t (IDLE/WAIT/RESP), addr_err() misalignment/range check.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A byte address is bad if it is not word aligned or if any bit above the
    // word-index field is set (prevents aliasing onto low words).
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - load/store request/response bundle between CPU datapath and responder
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake (master -> slave)
//   rsp_valid/rsp_rdata/rsp_err                    : single-cycle response (slave -> master)
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ram_1p.sv
// rtl/ram_1p.sv - single-port synchronous word RAM, read-during-write returns old data
//   clk   : clock
//   re    : read enable; rdata only changes on an enabled read and holds otherwise
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module ram_1p #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with WAIT_STATES latency in front of ram_1p
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : dmem_if.slave (req_valid/req_ready/req_we/req_addr/req_wdata, rsp_valid/rsp_rdata/rsp_err)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    zero_q, zero_d;       // force rsp_rdata to 0 (write or error)
    logic                    rsp_err_q, rsp_err_d;

    logic                    accept;
    logic                    req_err;
    logic                    ram_re;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;

    assign req_err = addr_err(bus.req_addr, ADDR_WIDTH);
    assign accept  = (state_q == IDLE) && bus.req_valid && !reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        zero_d    = zero_q;
        rsp_err_d = rsp_err_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = bus.req_we;
                    addr_d   = bus.req_addr[ADDR_WIDTH+1:2];
                    wdata_d  = bus.req_wdata;
                    err_d    = req_err;
                    zero_d   = bus.req_we || req_err;
                    // The RAM is read straight from the incoming address so the
                    // registered word is ready even with zero wait states.
                    ram_addr = bus.req_addr[ADDR_WIDTH+1:2];
                    ram_re   = !bus.req_we;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        // Acceptance edge is also the RESP-entry edge: commit now.
                        state_d   = RESP;
                        rsp_err_d = req_err;
                        ram_we    = bus.req_we && !req_err;
                        ram_wdata = bus.req_wdata;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    rsp_err_d = err_q;
                    ram_we    = we_q && !err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset on the would-be commit edge drops the write.
        if (reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            zero_q    <= 1'b1;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            zero_q    <= zero_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    ram_1p #(
        .AW (ADDR_WIDTH),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = zero_q ? '0 : ram_rdata;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WAIT_STATES 1 and 0)
module tb_dmem_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    dmem_if bus1 ();
    dmem_if bus0 ();

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction
    function automatic logic get_valid(input int sel);
        return (sel == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus0.rsp_err : bus1.rsp_err;
    endfunction

    // Called at a negedge. lat counts the accepting cycle as cycle 1.
    task automatic txn(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat, output int rcyc);
        int k;
        drive(sel, 1'b1, we, a, d);
        k = 0;
        while (!get_ready(sel) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("accept_timeout", 32'(k), 32'd0);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 2;
        while (!get_valid(sel) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd   = get_rdata(sel);
        er   = get_err(sel);
        rcyc = cyc;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rc;
    int          prev_rc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ready",  32'(get_ready(1)), 32'd0);
        check("rst_valid",  32'(get_valid(1)), 32'd0);
        check("rst_rdata",  get_rdata(1),      32'h0);
        check("rst_err",    32'(get_err(1)),   32'd0);
        check("rst_valid0", 32'(get_valid(0)), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(get_ready(1)), 32'd1);

        // write then read, WAIT_STATES=1
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, rc);
        check("wr10_err", 32'(er), 32'd0);
        check("wr10_rdata", rd, 32'h0);
        check("wr10_lat", 32'(lat), 32'd3);
        txn(1, 1'b0, 32'h10, 32'h0, rd, er, lat, rc);
        check("rd10_err", 32'(er), 32'd0);
        check("rd10_rdata", rd, 32'hDEADBEEF);
        check("rd10_lat", 32'(lat), 32'd3);

        // misaligned / out of range, no aliasing
        txn(1, 1'b1, 32'h0, 32'h11111111, rd, er, lat, rc);
        txn(1, 1'b0, 32'h12, 32'h0, rd, er, lat, rc);
        check("rd12_err", 32'(er), 32'd1);
        check("rd12_rdata", rd, 32'h0);
        txn(1, 1'b0, 32'h1000, 32'h0, rd, er, lat, rc);
        check("rd1000_err", 32'(er), 32'd1);
        check("rd1000_rdata", rd, 32'h0);
        txn(1, 1'b1, 32'h1000, 32'h00000BAD, rd, er, lat, rc);
        check("wr1000_err", 32'(er), 32'd1);
        txn(1, 1'b0, 32'h0, 32'h0, rd, er, lat, rc);
        check("rd0_noalias", rd, 32'h11111111);
        check("rd0_err", 32'(er), 32'd0);

        // WAIT_STATES=0 back-to-back
        prev_rc = 0;
        for (int i = 0; i < 8; i++) begin
            txn(0, (i < 4), 32'(4 * (i % 4)), 32'(i % 4 + 1), rd, er, lat, rc);
            check($sformatf("ws0_lat%0d", i), 32'(lat), 32'd2);
            if (i > 0) check($sformatf("ws0_spacing%0d", i), 32'(rc - prev_rc), 32'd2);
            if (i >= 4) check($sformatf("ws0_rdata%0d", i), rd, 32'(i - 3));
            prev_rc = rc;
        end

        // req_valid held with changing address during WAIT
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        check("hold_ready_idle", 32'(get_ready(1)), 32'd1);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        check("hold_ready_wait", 32'(get_ready(1)), 32'd0);
        check("hold_valid_wait", 32'(get_valid(1)), 32'd0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
        check("hold_ready_resp", 32'(get_ready(1)), 32'd0);
        check("hold_valid_resp", 32'(get_valid(1)), 32'd1);
        check("hold_rdata", get_rdata(1), 32'hDEADBEEF);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // reset during WAIT of a write; reset together with req_valid
        txn(1, 1'b1, 32'h20, 32'hAAAAAAAA, rd, er, lat, rc);
        txn(1, 1'b1, 32'h24, 32'h00000066, rd, er, lat, rc);
        drive(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("midrst_valid", 32'(get_valid(1)), 32'd0);
        check("midrst_ready", 32'(get_ready(1)), 32'd0);
        check("midrst_rdata", get_rdata(1), 32'h0);
        check("midrst_err", 32'(get_err(1)), 32'd0);
        drive(1, 1'b1, 1'b1, 32'h24, 32'h00000077);
        @(negedge clk);
        check("rstreq_valid", 32'(get_valid(1)), 32'd0);
        reset = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_valid%0d", i), 32'(get_valid(1)), 32'd0);
        end
        txn(1, 1'b0, 32'h20, 32'h0, rd, er, lat, rc);
        check("rd20_dropped", rd, 32'hAAAAAAAA);
        txn(1, 1'b0, 32'h24, 32'h0, rd, er, lat, rc);
        check("rd24_not_accepted", rd, 32'h00000066);

        // read-after-write, back-to-back
        txn(1, 1'b1, 32'h4, 32'h5, rd, er, lat, rc);
        prev_rc = rc;
        txn(1, 1'b0, 32'h4, 32'h0, rd, er, lat, rc);
        check("raw_rdata", rd, 32'h5);
        check("raw_spacing", 32'(rc - prev_rc), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
